// File: rtl/gray_arb_pkg.sv
// Shared types and helpers for the Gray-to-binary conversion arbiter.
// Holds the FSM state encoding, default sizes and the rotating first-one search.
package gray_arb_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_NUM_REQ = 4;
    localparam int MAX_REQ     = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    // First set bit of valid, searching upward from ptr and wrapping at n.
    function automatic int rr_first(
        input logic [MAX_REQ-1:0] valid,
        input int                 ptr,
        input int                 n
    );
        int         idx;
        int         c;
        logic [2:0] cidx;
        logic       hit;
        idx = 0;
        hit = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            c = ptr + k;
            if (c >= n) c = c - n;
            cidx = 3'(c);
            if (k < n && !hit && valid[cidx]) begin
                idx = c;
                hit = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/gray_to_bin_core.sv
// Pure combinational Gray-to-binary conversion.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin shared Gray-to-binary converter with a one-entry output stage.
// Define GRAY_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module gray_conv_arbiter
    import gray_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_gray,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_bin,
    output logic [ID_W-1:0]          out_id,
    input  logic                     out_ready
);

    state_t               state;
    state_t               state_nxt;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      grant_id;
    logic [MAX_REQ-1:0]   valid_ext;
    logic                 can_accept;
    logic                 grant_en;
    logic                 fire;
    logic [WIDTH-1:0]     sel_gray;
    logic [WIDTH-1:0]     sel_bin;

    always_comb begin
        valid_ext = '0;
        valid_ext[NUM_REQ-1:0] = req_valid;
    end

    assign can_accept = (state == ST_IDLE) || out_ready;
    assign grant_en   = rst_n && can_accept && (|req_valid);
    assign grant_id   = ID_W'(rr_first(valid_ext, int'(rr_ptr), NUM_REQ));
    assign req_ready  = grant_en ? (NUM_REQ'(1) << grant_id) : '0;
    assign fire       = grant_en;

    assign sel_gray = req_gray[int'(grant_id)*WIDTH +: WIDTH];

    gray_to_bin_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .gray (sel_gray),
        .bin  (sel_bin)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (fire) state_nxt = ST_FULL;
            ST_FULL: begin
                if (fire)           state_nxt = ST_FULL;
                else if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            out_bin <= '0;
            out_id  <= '0;
        end else begin
            state <= state_nxt;
            if (fire) begin
                out_bin <= sel_bin;
                out_id  <= grant_id;
            end
        end
    end

    assign out_valid = (state == ST_FULL);

`ifdef GRAY_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    // Pointer moves just past the winner so it drops to lowest priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (fire) begin
            if (grant_id == ID_W'(NUM_REQ - 1)) rr_ptr <= '0;
            else                                 rr_ptr <= grant_id + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed self-checking bench for gray_conv_arbiter (WIDTH=4, NUM_REQ=4).
// Expected values are hand-computed Gray-to-binary results and grant orders.
module tb_gray_conv_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_gray;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [3:0]  out_bin;
    logic [1:0]  out_id;
    logic        out_ready;

    int n_cmp = 0;
    int n_err = 0;

    gray_conv_arbiter #(
        .WIDTH   (4),
        .NUM_REQ (4),
        .ID_W    (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_gray  (req_gray),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_bin   (out_bin),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hand-computed binary value for each 4-bit Gray code.
    logic [3:0] g2b [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd7, 4'd6, 4'd4, 4'd5,
                             4'd15, 4'd14, 4'd12, 4'd13, 4'd8, 4'd9, 4'd11, 4'd10};

`ifdef GRAY_ARB_FIXED_PRIO_EN
    logic [1:0] seq_id [5] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [1:0] resume_id = 2'd0;
`else
    logic [1:0] seq_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] resume_id = 2'd1;
`endif

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_gray  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_bin", out_bin, 4'h0);
        chk("rst_out_id", out_id, 2'd0);
        chk("rst_req_ready", req_ready, 4'h0);
        rst_n     = 1'b1;
        req_valid = 4'h0;
        @(posedge clk);
        #1;

        // single request
        req_valid = 4'b0001;
        req_gray[0 +: 4] = 4'b0110;
        out_ready = 1'b1;
        #1;
        chk("t1_ready", req_ready, 4'b0001);
        @(posedge clk);
        #1;
        req_valid = 4'h0;
        #1;
        chk("t1_out_valid", out_valid, 1'b1);
        chk("t1_out_bin", out_bin, 4'b0100);
        chk("t1_out_id", out_id, 2'd0);
        @(posedge clk);
        #1;
        chk("t1_drain", out_valid, 1'b0);

        // requester 3 alone: pointer wraps back to 0
        req_valid = 4'b1000;
        req_gray[12 +: 4] = 4'b1010;
        #1;
        chk("wrap_ready", req_ready, 4'b1000);
        @(posedge clk);
        #1;
        chk("wrap_out_bin", out_bin, 4'b1100);
        chk("wrap_out_id", out_id, 2'd3);

        // all valid, full throughput
        req_valid = 4'hF;
        req_gray  = {4'b1000, 4'b1000, 4'b1000, 4'b1000};
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t2_ready", req_ready, 4'b0001 << seq_id[k]);
            @(posedge clk);
            #1;
            chk("t2_out_valid", out_valid, 1'b1);
            chk("t2_out_id", out_id, seq_id[k]);
            chk("t2_out_bin", out_bin, 4'b1111);
        end

        // backpressure
        out_ready = 1'b0;
        req_gray  = {4'b0000, 4'b0000, 4'b0000, 4'b0000};
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t3_ready", req_ready, 4'h0);
            chk("t3_out_valid", out_valid, 1'b1);
            chk("t3_out_id", out_id, 2'd0);
            chk("t3_out_bin", out_bin, 4'b1111);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        chk("t3_resume_ready", req_ready, 4'b0001 << resume_id);
        @(posedge clk);
        #1;
        chk("t3_resume_id", out_id, resume_id);
        chk("t3_resume_bin", out_bin, 4'b0000);

        // simultaneous drain and fill
        req_valid = 4'b0100;
        req_gray[8 +: 4] = 4'b0001;
        #1;
        chk("t4_ready", req_ready, 4'b0100);
        @(posedge clk);
        #1;
        chk("t4_out_valid", out_valid, 1'b1);
        chk("t4_out_bin", out_bin, 4'b0001);
        chk("t4_out_id", out_id, 2'd2);

        // reset while full
        rst_n = 1'b0;
        #1;
        chk("t5_out_valid", out_valid, 1'b0);
        chk("t5_out_bin", out_bin, 4'h0);
        chk("t5_out_id", out_id, 2'd0);
        chk("t5_ready", req_ready, 4'h0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 4'b0110;
        req_gray[4 +: 4] = 4'b0011;
        #1;
        chk("t5_first_ready", req_ready, 4'b0010);
        @(posedge clk);
        #1;
        chk("t5_first_id", out_id, 2'd1);
        chk("t5_first_bin", out_bin, 4'b0010);

        // every Gray code through requester 3
        req_valid = 4'b1000;
        for (int g = 0; g < 16; g++) begin
            req_gray[12 +: 4] = 4'(g);
            #1;
            chk("t6_ready", req_ready, 4'b1000);
            @(posedge clk);
            #1;
            chk("t6_out_bin", out_bin, g2b[g]);
            chk("t6_out_id", out_id, 2'd3);
        end

        req_valid = 4'h0;
        @(posedge clk);
        #1;
        chk("t6_idle", out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
